lcd1602_bus_monitor: RTL
========================

# lcd1602_bus_monitor

Passive receiver for the HD44780-style 8-bit parallel bus (rs, rw, enable, data) driven by the LCD1602 controller. It decodes each enable strobe into a command or data write and tracks the address counter and display state the way the panel does. It also keeps a shadow of the visible 2x16 DDRAM window and the 64-byte CGRAM. The block sits next to the controller in simulation benches and on-board self-check builds, so screen contents (face glyphs, feed/joy/energy bars) can be read back and compared without a physical panel.

## Interface
- MIN_EN_HIGH, 2: minimum synchronized enable-high run, in clk cycles, for a strobe to count.
- SWEEP_LEN, 32: number of DDRAM shadow entries filled with 0x20 by a clear sweep. Fixed at 2 lines x 16.
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rs  in  1  register select from controller (0 = command, 1 = data)
- rw  in  1  read/write from controller (0 = write)
- enable  in  1  bus strobe; data is latched on its falling edge
- data  in  8  bus data
- rd_addr  in  7  shadow read address: bit6=1 selects CGRAM[5:0]; bit6=0 selects DDRAM index [4:0] (index = line*16 + column)
- rd_data  out  8  shadow read data, registered
- cmd_valid  out  1  one-cycle pulse: a command was decoded
- cmd_code  out  8  command byte, held until the next command
- wr_valid  out  1  one-cycle pulse: a data write was decoded
- wr_is_cgram  out  1  target of the last data write (1 = CGRAM)
- wr_addr  out  7  address counter value used by the last data write
- wr_data  out  8  byte of the last data write
- ac  out  7  current address counter
- cgram_mode  out  1  address counter currently points into CGRAM
- entry_inc, display_on, cursor_on, blink_on  out  1 each  decoded mode bits
- init_done  out  1  at least one function-set command has been seen
- fs_ok  out  1  the last function set was 8-bit, 2-line, 5x8
- busy  out  1  clear sweep in progress
- err_rw, err_glitch, err_overrun  out  1 each  sticky error flags; cleared only by reset
- strobe_count  out  16  accepted strobes; saturates at 0xFFFF

## Operation
- enable, rs, rw and data each pass through a 2-flop synchronizer.
- Falling edge: a third enable flop is high and the second-stage enable flop is low.
- A high-run counter tracks the synchronized enable. If a falling edge follows a run shorter than MIN_EN_HIGH, the strobe is dropped and err_glitch is set.
- Strobe with rw=1: dropped, err_rw set.
- Accepted strobes increment strobe_count.
- Command decode (rs=0), priority by highest set bit:
  - 0x01 clear: ac=0, DDRAM mode, entry_inc=1, start sweep.
  - 0x02/0x03 home: ac=0, DDRAM mode.
  - 0x04–0x07 entry mode: entry_inc=data[1]; the shift bit is ignored.
  - 0x08–0x0F display control: display_on=d[2], cursor_on=d[1], blink_on=d[0].
  - 0x10–0x1F shift: if d[3]=0, step ac by one in the direction d[2]; display shift is ignored.
  - 0x20–0x3F function set: init_done=1; fs_ok = (d[4:2]==3'b110).
  - 0x40–0x7F: ac=d[5:0], CGRAM mode.
  - 0x80–0xFF: ac=d[6:0], DDRAM mode.
- Data write (rs=1):
  - CGRAM mode: write CGRAM[ac[5:0]].
  - DDRAM mode: write the shadow only when ac is in 0x00–0x0F or 0x40–0x4F, at index {ac[6],ac[3:0]}. Writes outside the window update nothing except ac.
  - ac then steps per entry_inc.
- Address counter stepping:
  - DDRAM increment wraps 0x27→0x40 and 0x67→0x00.
  - DDRAM decrement wraps 0x00→0x67 and 0x40→0x27.
  - CGRAM steps modulo 64.
- Clear sweep:
  - Writes 0x20 to DDRAM shadow indices 0..31, one per cycle; busy is high for 32 cycles.
  - A strobe arriving during the sweep is held in a one-entry pending slot and processed on the cycle after busy falls.
  - A second strobe while the slot is full is dropped, sets err_overrun, and is not counted.
- rd_data returns whatever the shadow holds, including mid-sweep contents. The CGRAM shadow is not reset.

## Timing
- Reset values:
  - 0: all pulses, cmd_code, wr_* outputs, ac, cgram_mode, display_on, cursor_on, blink_on, init_done, fs_ok, all error flags, strobe_count, rd_data.
  - 1: entry_inc.
  - busy=1: a 32-cycle sweep starts on the first cycle after reset deasserts.
- Latency: cmd_valid/wr_valid pulse, state update and shadow write all occur 3 clk after the first rising edge that samples enable low.
- rd_data is valid 1 clk after rd_addr. A read of an index written in the same cycle returns the old value.
- Pending strobe: its outputs pulse exactly 1 clk after busy deasserts.
- Reset asserted mid-sweep or mid-strobe: everything is re-initialised and the sweep restarts from index 0.

## Test plan
- Reset, wait 32 cycles, then read all DDRAM indices -> busy falls at cycle 32; every entry reads 0x20.
- Send 0x38, 0x0C, 0x06, 0x01, then 0x80 followed by data 'A','B' -> fs_ok=1, display_on=1, cursor_on=0; shadow[0]=0x41, shadow[1]=0x42; ac=0x02; strobe_count=7.
- Send 0xC0 followed by 16 data bytes -> shadow indices 16..31 are written; ac ends at 0x50. Then 0xA7 plus one data byte -> ac wraps 0x27→0x40, that write goes to no shadow entry, and ac ends at 0x40.
- Send 0x40 followed by 65 data bytes -> CGRAM[0] holds the 65th byte; ac=0x01 in CGRAM mode.
- Send a 1-cycle enable pulse, then a strobe with rw=1 -> both are dropped; err_glitch=1, err_rw=1, strobe_count unchanged.
- Send 0x01, then two data strobes 4 cycles apart during the sweep -> the first is processed 1 clk after busy falls and writes shadow[0]; the second is dropped and err_overrun=1.

Source files
------------

// File: rtl/lcd1602_bus_monitor.sv
// lcd1602_bus_monitor: passive HD44780 8-bit bus decoder. Tracks the address
// counter and mode bits like the panel does and keeps a readable shadow of the
// visible 2x16 DDRAM window and the 64-byte CGRAM.
module lcd1602_bus_monitor #(
  parameter int MIN_EN_HIGH = 2,
  parameter int SWEEP_LEN   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rs,
  input  logic        rw,
  input  logic        enable,
  input  logic [7:0]  data,
  input  logic [6:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        wr_valid,
  output logic        wr_is_cgram,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  ac,
  output logic        cgram_mode,
  output logic        entry_inc,
  output logic        display_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        init_done,
  output logic        fs_ok,
  output logic        busy,
  output logic        err_rw,
  output logic        err_glitch,
  output logic        err_overrun,
  output logic [15:0] strobe_count
);
  logic       en_s1_q, en_s2_q, en_s3_q, rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0] data_s1_q, data_s2_q, run_q;
  logic       stb_q, stb_rs_q, pend_q, pend_rs_q;
  logic [7:0] stb_data_q, pend_data_q;
  logic       err_rw_q, err_glitch_q, err_overrun_q;
  logic       sweep_q;
  logic [4:0] sweep_idx_q;
  logic [7:0] ddram_q [32];
  logic [7:0] cgram_q [64];
  logic [7:0] rd_data_q;

  logic [6:0]  ac_q, ac_d, wr_addr_q, wr_addr_d;
  logic [7:0]  cmd_code_q, cmd_code_d, wr_data_q, wr_data_d;
  logic [15:0] count_q, count_d;
  logic cgram_mode_q, cgram_mode_d, entry_inc_q, entry_inc_d;
  logic display_on_q, display_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
  logic init_done_q, init_done_d, fs_ok_q, fs_ok_d;
  logic cmd_valid_q, cmd_valid_d, wr_valid_q, wr_valid_d, wr_is_cgram_q, wr_is_cgram_d;

  logic       fall, short_run, do_proc, proc_rs, sweep_start, dd_we, cg_we;
  logic [7:0] proc_data;

  assign fall      = en_s3_q & ~en_s2_q;
  assign short_run = run_q < 8'(MIN_EN_HIGH);

  // DDRAM steps along the 0x00-0x27 / 0x40-0x67 ring; CGRAM wraps at 64.
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic cg, input logic up);
    if (cg) return {1'b0, (up ? a[5:0] + 6'd1 : a[5:0] - 6'd1)};
    if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  // Synchronize the bus and measure the enable-high run length.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {en_s1_q, en_s2_q, en_s3_q, rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q} <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      run_q     <= '0;
    end else begin
      en_s1_q   <= enable;
      en_s2_q   <= en_s1_q;
      en_s3_q   <= en_s2_q;
      rs_s1_q   <= rs;
      rs_s2_q   <= rs_s1_q;
      rw_s1_q   <= rw;
      rw_s2_q   <= rw_s1_q;
      data_s1_q <= data;
      data_s2_q <= data_s1_q;
      if (en_s2_q) begin
        if (run_q != 8'hFF) run_q <= run_q + 8'd1;
      end else begin
        run_q <= '0;
      end
    end
  end

  // Qualify falling edges into strobes and park one strobe while a sweep runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {stb_q, stb_rs_q, pend_q, pend_rs_q} <= '0;
      stb_data_q  <= '0;
      pend_data_q <= '0;
      {err_glitch_q, err_rw_q, err_overrun_q} <= '0;
    end else begin
      stb_q <= 1'b0;
      if (fall) begin
        if (short_run) err_glitch_q <= 1'b1;
        else if (rw_s2_q) err_rw_q <= 1'b1;
        else begin
          stb_q      <= 1'b1;
          stb_rs_q   <= rs_s2_q;
          stb_data_q <= data_s2_q;
        end
      end
      if (sweep_q) begin
        if (stb_q) begin
          if (pend_q) err_overrun_q <= 1'b1;
          else begin
            pend_q      <= 1'b1;
            pend_rs_q   <= stb_rs_q;
            pend_data_q <= stb_data_q;
          end
        end
      end else if (pend_q) begin
        // Pending strobe is consumed now; a strobe arriving this cycle takes its place.
        pend_q      <= stb_q;
        pend_rs_q   <= stb_rs_q;
        pend_data_q <= stb_data_q;
      end
    end
  end

  // Pick the strobe to execute: the parked one first once the sweep ends.
  always_comb begin
    do_proc   = 1'b0;
    proc_rs   = stb_rs_q;
    proc_data = stb_data_q;
    if (!sweep_q) begin
      if (pend_q) begin
        do_proc   = 1'b1;
        proc_rs   = pend_rs_q;
        proc_data = pend_data_q;
      end else if (stb_q) begin
        do_proc = 1'b1;
      end
    end
  end

  // Decode the executed strobe into next architectural state.
  always_comb begin
    ac_d = ac_q;  cgram_mode_d = cgram_mode_q;  entry_inc_d = entry_inc_q;
    display_on_d = display_on_q;  cursor_on_d = cursor_on_q;  blink_on_d = blink_on_q;
    init_done_d = init_done_q;  fs_ok_d = fs_ok_q;  count_d = count_q;
    cmd_valid_d = 1'b0;  cmd_code_d = cmd_code_q;
    wr_valid_d = 1'b0;  wr_is_cgram_d = wr_is_cgram_q;  wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;
    sweep_start = 1'b0;  dd_we = 1'b0;  cg_we = 1'b0;
    if (do_proc) begin
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      if (!proc_rs) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = proc_data;
        casez (proc_data)
          8'b1???????: begin ac_d = proc_data[6:0]; cgram_mode_d = 1'b0; end
          8'b01??????: begin ac_d = {1'b0, proc_data[5:0]}; cgram_mode_d = 1'b1; end
          8'b001?????: begin init_done_d = 1'b1; fs_ok_d = (proc_data[4:2] == 3'b110); end
          8'b0001????: if (!proc_data[3]) ac_d = step_ac(ac_q, cgram_mode_q, proc_data[2]);
          8'b00001???: begin
            display_on_d = proc_data[2];
            cursor_on_d  = proc_data[1];
            blink_on_d   = proc_data[0];
          end
          8'b000001??: entry_inc_d = proc_data[1];
          8'b0000001?: begin ac_d = '0; cgram_mode_d = 1'b0; end
          8'b00000001: begin
            ac_d = '0; cgram_mode_d = 1'b0; entry_inc_d = 1'b1; sweep_start = 1'b1;
          end
          default: ;
        endcase
      end else begin
        wr_valid_d    = 1'b1;
        wr_is_cgram_d = cgram_mode_q;
        wr_addr_d     = ac_q;
        wr_data_d     = proc_data;
        if (cgram_mode_q) cg_we = 1'b1;
        else if (ac_q[5:4] == 2'b00) dd_we = 1'b1;
        ac_d = step_ac(ac_q, cgram_mode_q, entry_inc_q);
      end
    end
  end

  // Architectural state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ac_q <= '0;  cgram_mode_q <= 1'b0;  entry_inc_q <= 1'b1;
      {display_on_q, cursor_on_q, blink_on_q, init_done_q, fs_ok_q} <= '0;
      count_q <= '0;  cmd_valid_q <= 1'b0;  cmd_code_q <= '0;
      wr_valid_q <= 1'b0;  wr_is_cgram_q <= 1'b0;  wr_addr_q <= '0;  wr_data_q <= '0;
    end else begin
      ac_q <= ac_d;  cgram_mode_q <= cgram_mode_d;  entry_inc_q <= entry_inc_d;
      display_on_q <= display_on_d;  cursor_on_q <= cursor_on_d;  blink_on_q <= blink_on_d;
      init_done_q <= init_done_d;  fs_ok_q <= fs_ok_d;
      count_q <= count_d;  cmd_valid_q <= cmd_valid_d;  cmd_code_q <= cmd_code_d;
      wr_valid_q <= wr_valid_d;  wr_is_cgram_q <= wr_is_cgram_d;
      wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
    end
  end

  // Clear sweep: reset and the clear command both restart it from index 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sweep_q     <= 1'b1;
      sweep_idx_q <= '0;
    end else if (sweep_q) begin
      sweep_idx_q <= sweep_idx_q + 5'd1;
      if (sweep_idx_q == 5'(SWEEP_LEN - 1)) sweep_q <= 1'b0;
    end else if (sweep_start) begin
      sweep_q     <= 1'b1;
      sweep_idx_q <= '0;
    end
  end

  // Shadow memories; CGRAM has no reset, matching the panel.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (sweep_q) ddram_q[sweep_idx_q] <= 8'h20;
      else if (dd_we) ddram_q[{ac_q[6], ac_q[3:0]}] <= proc_data;
      if (cg_we) cgram_q[ac_q[5:0]] <= proc_data;
    end
  end

  // Registered shadow read port.
  always_ff @(posedge clk) begin
    if (!reset) rd_data_q <= '0;
    else rd_data_q <= rd_addr[6] ? cgram_q[rd_addr[5:0]] : ddram_q[rd_addr[4:0]];
  end

  assign rd_data      = rd_data_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign wr_valid     = wr_valid_q;
  assign wr_is_cgram  = wr_is_cgram_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign ac           = ac_q;
  assign cgram_mode   = cgram_mode_q;
  assign entry_inc    = entry_inc_q;
  assign display_on   = display_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign init_done    = init_done_q;
  assign fs_ok        = fs_ok_q;
  assign busy         = sweep_q;
  assign err_rw       = err_rw_q;
  assign err_glitch   = err_glitch_q;
  assign err_overrun  = err_overrun_q;
  assign strobe_count = count_q;
endmodule
